v_sync_line_generator: RTL and testbench
========================================

# v_sync_line_generator

Vertical timing stage fed directly by the horizontal sync generator. It detects the start of each line on the rising edge of `h_sync`, and counts lines within a frame. It produces `v_sync`, a vertical-active flag, and single-cycle line/frame start strobes. Its outputs feed the pixel address logic and the VGA output pins alongside `h_sync`.

## Interface
- `V_VISIBLE`, 768: visible lines per frame
- `V_FRONT`, 3: front-porch lines
- `V_SYNC`, 6: sync-pulse lines
- `V_BACK`, 29: back-porch lines; total lines `V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK` (806)
- `LINE_COUNTER_SIZE`, 10: width of line counter; must satisfy `2^LINE_COUNTER_SIZE >= V_TOTAL`
- `V_SYNC_ACTIVE`, 1'b0: output level of `v_sync` during the sync lines

Ports:
- `control_clock`  in  1  single clock for the whole block; the same clock as the horizontal sync generator
- `control_reset_n`  in  1  asynchronous, active-low reset
- `h_sync`  in  1  horizontal sync from the horizontal sync generator, synchronous to `control_clock`; its rising edge marks line start (h counter at zero)
- `line_count`  out  LINE_COUNTER_SIZE  current line number, 0..V_TOTAL-1
- `v_sync`  out  1  vertical sync, registered
- `v_active`  out  1  high while `line_count < V_VISIBLE` and in RUN state
- `line_start`  out  1  one-cycle strobe at each accepted line start
- `frame_start`  out  1  one-cycle strobe when line 0 begins

## Operation
- Edge detect: register `h_sync_d`. `line_tick = h_sync & ~h_sync_d`. `h_sync_d` resets to 1, so an `h_sync` already high at reset release is not a tick.
- FSM, two states:
  - WAIT_FIRST (reset state): `line_count` held 0; `v_active`=0; `v_sync`=!V_SYNC_ACTIVE. On `line_tick`: go to RUN, `line_count`=0, `line_start`=1, `frame_start`=1.
  - RUN: on `line_tick`, `line_count` increments by 1; at `V_TOTAL-1` it wraps to 0 instead. `line_start`=1 on every tick. `frame_start`=1 only on the wrap to 0. Without a tick, all state holds.
- `v_sync` = V_SYNC_ACTIVE when the next `line_count` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (lines 771..776 at defaults); otherwise inactive. It is computed from the next value so it stays aligned with `line_count`.
- `v_active` = RUN && next `line_count` < V_VISIBLE (lines 0..767).
- Arithmetic is unsigned, LINE_COUNTER_SIZE bits. The counter never exceeds V_TOTAL-1.
- No spurious ticks: `h_sync` held high produces exactly one tick; `h_sync` held low produces none.

## Timing
- All outputs are registered and update only on rising `control_clock`.
- Latency: the rising edge of `h_sync` is sampled in cycle n. The new `line_count`, `v_sync`, `v_active` and strobes are visible in cycle n+1.
- Strobes last exactly one cycle. Minimum `h_sync` spacing is 2 cycles (high-low-high); ticks at that spacing are all counted.
- Reset (asynchronous assert, deasserted synchronously by system):
  - `line_count`=0
  - `v_sync`=!V_SYNC_ACTIVE
  - `v_active`=0
  - `line_start`=0
  - `frame_start`=0
  - state=WAIT_FIRST
  - `h_sync_d`=1
- Reset asserted mid-frame forces these values immediately, independent of the clock. After release, the block waits for a fresh rising `h_sync` before restarting at line 0.
- A wrap and a tick are a single event: the tick that causes the wrap produces `line_count`=0, `frame_start`=1 and `line_start`=1 in the same cycle.

## Test plan
- Reset: assert `control_reset_n`=0 with the clock running → `line_count`=0, `v_sync`=1, `v_active`=0, both strobes 0. Release with `h_sync`=1 held → no strobe, state stays WAIT_FIRST.
- First line: drive `h_sync` 0→1 → one cycle later `frame_start`=`line_start`=1 for one cycle, `line_count`=0, `v_active`=1.
- Sync window: drive 1328-clock lines, 1072-clock high (h_sync generator defaults) → `v_sync`=0 exactly for lines 771..776. `v_active` falls when `line_count` becomes 768.
- Wrap: advance to line 805, then one more tick → `line_count`=0, `frame_start` pulses once, `v_active`=1. Exactly one `frame_start` per 806 `line_start` pulses over 3 frames.
- Reset mid-frame: at line 400, pulse `control_reset_n` low without a clock edge → outputs return to reset values immediately. The next `h_sync` rise restarts at line 0 with `frame_start`.
- Edge robustness: `h_sync` high-low-high at 2-cycle spacing → two `line_start` pulses and `line_count` +2. `h_sync` held high for 5000 cycles → count unchanged.

Source files
------------

// File: rtl/v_sync_line_generator.sv
// Vertical timing stage: counts lines on each rising edge of h_sync and derives
// v_sync, v_active and one-cycle line/frame start strobes, all registered.
module v_sync_line_generator #(
    parameter int unsigned V_VISIBLE         = 768,
    parameter int unsigned V_FRONT           = 3,
    parameter int unsigned V_SYNC            = 6,
    parameter int unsigned V_BACK            = 29,
    parameter int unsigned LINE_COUNTER_SIZE = 10,
    parameter logic        V_SYNC_ACTIVE     = 1'b0
) (
    input  logic                         control_clock,
    input  logic                         control_reset_n,
    input  logic                         h_sync,
    output logic [LINE_COUNTER_SIZE-1:0] line_count,
    output logic                         v_sync,
    output logic                         v_active,
    output logic                         line_start,
    output logic                         frame_start
);

    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [LINE_COUNTER_SIZE-1:0] LAST_LINE     = LINE_COUNTER_SIZE'(V_TOTAL - 1);
    localparam logic [LINE_COUNTER_SIZE-1:0] VISIBLE_LIMIT = LINE_COUNTER_SIZE'(V_VISIBLE);
    localparam logic [LINE_COUNTER_SIZE-1:0] SYNC_FIRST    = LINE_COUNTER_SIZE'(V_VISIBLE + V_FRONT);
    localparam logic [LINE_COUNTER_SIZE-1:0] SYNC_LAST     = LINE_COUNTER_SIZE'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [LINE_COUNTER_SIZE-1:0] COUNT_ONE     = LINE_COUNTER_SIZE'(1);

    typedef enum logic {
        WAIT_FIRST,
        RUN
    } state_t;

    state_t                         r_state;
    logic                           r_h_sync_d;
    logic [LINE_COUNTER_SIZE-1:0]   r_line_count;
    logic                           r_v_sync;
    logic                           r_v_active;
    logic                           r_line_start;
    logic                           r_frame_start;

    logic                           w_line_tick;
    logic [LINE_COUNTER_SIZE-1:0]   w_next_count;
    logic                           w_in_sync;

    // The first accepted line after reset always starts the frame at line 0.
    always_comb begin
        w_line_tick  = h_sync & ~r_h_sync_d;
        w_next_count = '0;
        if (r_state == RUN && r_line_count != LAST_LINE) begin
            w_next_count = r_line_count + COUNT_ONE;
        end
        w_in_sync = (w_next_count >= SYNC_FIRST) && (w_next_count <= SYNC_LAST);
    end

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_state       <= WAIT_FIRST;
            r_h_sync_d    <= 1'b1;
            r_line_count  <= '0;
            r_v_sync      <= ~V_SYNC_ACTIVE;
            r_v_active    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_sync_d    <= h_sync;
            r_line_start  <= w_line_tick;
            r_frame_start <= w_line_tick && (w_next_count == '0);
            if (w_line_tick) begin
                r_state      <= RUN;
                r_line_count <= w_next_count;
                r_v_sync     <= w_in_sync ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
                r_v_active   <= (w_next_count < VISIBLE_LIMIT);
            end
        end
    end

    assign line_count  = r_line_count;
    assign v_sync      = r_v_sync;
    assign v_active    = r_v_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_v_sync_line_generator.sv
// Self-checking bench for v_sync_line_generator: a tick-counting reference model
// is compared against the DUT every cycle, plus literal spot checks.
module tb_v_sync_line_generator;

    localparam int V_VISIBLE = 768;
    localparam int V_TOTAL   = 806;
    localparam int SYNC_LO   = 771;
    localparam int SYNC_HI   = 776;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       hSync   = 1'b1;
    logic [9:0] lineCount;
    logic       vSync;
    logic       vActive;
    logic       lineStart;
    logic       frameStart;

    int total = 0;
    int bad   = 0;
    int lineStartSeen  = 0;
    int frameStartSeen = 0;

    // Model state: number of accepted line starts since reset, and last sampled h_sync.
    int   mTicks  = 0;
    logic mPrevH  = 1'b1;
    logic mStrobe = 1'b0;

    v_sync_line_generator dut (
        .control_clock   (clock),
        .control_reset_n (reset_n),
        .h_sync          (hSync),
        .line_count      (lineCount),
        .v_sync          (vSync),
        .v_active        (vActive),
        .line_start      (lineStart),
        .frame_start     (frameStart)
    );

    always #5 clock = ~clock;

    // Reference model tracks only the tick count; all outputs are derived arithmetically from it.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mTicks  <= 0;
            mPrevH  <= 1'b1;
            mStrobe <= 1'b0;
        end else begin
            mPrevH  <= hSync;
            mStrobe <= hSync && !mPrevH;
            if (hSync && !mPrevH) mTicks <= mTicks + 1;
        end
    end

    function automatic int expLine();
        return (mTicks == 0) ? 0 : (mTicks - 1) % V_TOTAL;
    endfunction

    // Compares every output of the DUT against the model in one go.
    task automatic checkOutput();
        int   line;
        logic eActive, eSync, eLs, eFs;
        line    = expLine();
        eActive = (mTicks > 0) && (line < V_VISIBLE);
        eSync   = !((mTicks > 0) && (line >= SYNC_LO) && (line <= SYNC_HI));
        eLs     = mStrobe;
        eFs     = mStrobe && (line == 0);
        total++;
        if (lineCount !== 10'(line) || vSync !== eSync || vActive !== eActive ||
            lineStart !== eLs || frameStart !== eFs) begin
            bad++;
            $display("[TB] FAIL cycle t=%0t got line=%0d vs=%b va=%b ls=%b fs=%b expected line=%0d vs=%b va=%b ls=%b fs=%b",
                     $time, lineCount, vSync, vActive, lineStart, frameStart, line, eSync, eActive, eLs, eFs);
        end
        lineStartSeen  += int'(lineStart === 1'b1);
        frameStartSeen += int'(frameStart === 1'b1);
    endtask

    task automatic checkLit(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // One clock: compare at the falling edge, return 2 time units after the rising edge.
    task automatic tick1();
        @(negedge clock);
        checkOutput();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input int hi, input int lo);
        hSync = 1'b1;
        repeat (hi) tick1();
        hSync = 1'b0;
        repeat (lo) tick1();
    endtask

    task automatic randomLine();
        applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    endtask

    task automatic advanceTo(input int target);
        int guard;
        guard = 0;
        while (expLine() != target && guard < 2000) begin
            randomLine();
            guard++;
        end
        if (guard >= 2000) checkLit("advance_timeout", guard, 0);
    endtask

    // Raises h_sync and stops in the cycle where the resulting strobes are visible.
    task automatic peekStart(input string name, input int expLineVal);
        hSync = 1'b1;
        tick1();
        @(negedge clock);
        checkOutput();
        checkLit({name, "_frame_start"}, int'(frameStart), 1);
        checkLit({name, "_line_start"}, int'(lineStart), 1);
        checkLit({name, "_line_count"}, int'(lineCount), expLineVal);
        checkLit({name, "_v_active"}, int'(vActive), 1);
        @(posedge clock);
        #2;
    endtask

    initial begin
        int lsBase, fsBase;

        @(posedge clock);
        #2;
        repeat (3) tick1();
        checkLit("reset_line_count", int'(lineCount), 0);
        checkLit("reset_v_sync", int'(vSync), 1);
        checkLit("reset_v_active", int'(vActive), 0);
        checkLit("reset_strobes", int'({lineStart, frameStart}), 0);

        // Release with h_sync already high: no line may start.
        reset_n = 1'b1;
        repeat (4) tick1();
        checkLit("hold_high_after_reset_ls", int'(lineStart), 0);
        checkLit("hold_high_after_reset_va", int'(vActive), 0);

        hSync = 1'b0;
        repeat (2) tick1();
        peekStart("first_line", 0);
        repeat (2) tick1();
        hSync = 1'b0;
        repeat (2) tick1();

        applyStimulus(1072, 256);
        checkLit("long_line_count", int'(lineCount), 1);

        applyStimulus(1, 1);
        applyStimulus(1, 1);
        checkLit("fast_ticks_count", int'(lineCount), 3);

        advanceTo(767);
        checkLit("line767_v_active", int'(vActive), 1);
        randomLine();
        checkLit("line768_v_active", int'(vActive), 0);
        advanceTo(770);
        checkLit("line770_v_sync", int'(vSync), 1);
        randomLine();
        checkLit("line771_v_sync", int'(vSync), 0);
        advanceTo(776);
        checkLit("line776_v_sync", int'(vSync), 0);
        randomLine();
        checkLit("line777_v_sync", int'(vSync), 1);
        advanceTo(805);
        checkLit("line805_count", int'(lineCount), 805);

        lsBase = lineStartSeen;
        fsBase = frameStartSeen;
        peekStart("wrap", 0);
        hSync = 1'b0;
        repeat (2) tick1();
        repeat (3 * V_TOTAL - 1) randomLine();
        checkLit("three_frames_line_starts", lineStartSeen - lsBase, 3 * V_TOTAL);
        checkLit("three_frames_frame_starts", frameStartSeen - fsBase, 3);
        checkLit("three_frames_end_line", int'(lineCount), 805);

        advanceTo(400);
        checkLit("line400_count", int'(lineCount), 400);
        reset_n = 1'b0;
        #1;
        checkOutput();
        checkLit("async_reset_line_count", int'(lineCount), 0);
        checkLit("async_reset_v_sync", int'(vSync), 1);
        checkLit("async_reset_v_active", int'(vActive), 0);
        reset_n = 1'b1;
        repeat (3) tick1();
        checkLit("after_reset_idle_count", int'(lineCount), 0);
        peekStart("restart", 0);
        hSync = 1'b0;
        repeat (2) tick1();

        hSync = 1'b1;
        repeat (5000) tick1();
        checkLit("long_high_count", int'(lineCount), 1);
        hSync = 1'b0;
        repeat (3) tick1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
